control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit for the bus-based CPU datapath.
- It is the producer of every strobe the datapath consumes: bus-source select, register enables, ALU op, and memory Read/Write.
- It runs a fetch/decode/execute state machine over the IR.
- It holds in memory states on a ready handshake, with a timeout counter.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles spent waiting for mem_rdy before entering FAULT (range 1-255).
- ADD_OP, 5'b00011: ALU op code driven for address calculation and increment.

Ports:
- Clock  in  1  rising-edge clock
- clr  in  1  synchronous, active-high reset
- ir  in  32  current IR contents from the datapath
- mem_rdy  in  1  memory completed the current Read/Write this cycle
- stop  in  1  request halt at the next instruction boundary
- bus_src  out  24  one-hot bus driver select: [15:0]=R0..R15out, 16=HIout, 17=LOout, 18=ZHIout, 19=ZLOout, 20=PCout, 21=MDRout, 22=InPortout, 23=Cout (sign-extended ir[18:0]); all-zero means the bus is idle
- reg_in  out  16  R0..R15 load enables (at most one hot)
- MARin, MDRin, PCin, IRin, Yin, Zin, IncPC  out  1 each  datapath load strobes
- Read, Write  out  1 each  memory request; held while waiting
- alu_op  out  5  ALU operation select
- run  out  1  high while sequencing
- fault  out  1  sticky; set by a memory timeout

Behaviour:
- Outputs are Moore: decoded from the state register, plus ir fields in execute states.
- Reset:
  - On an edge with clr=1: state=RESET, wait counter=0, fault=0.
  - All strobes, bus_src, reg_in and alu_op are 0; run=0.
  - clr overrides everything, including mid-instruction and mid-wait; a memory access in progress is simply abandoned.
- Fields: op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
- Decoded ops:
  - ld=00000, st=00010
  - R-type: add=00011, sub=00100, and=00101, or=00110
  - I-type: addi=01100, andi=01101, ori=01110
  - nop=11011, halt=11100
  - Every other op executes as nop.
- States and actions:
  - RESET: all outputs 0. Next state T0.
  - T0: bus_src[20], MARin, IncPC, Zin, alu_op=ADD_OP. run=1 from this state on.
  - T1: bus_src[19], PCin (first cycle only), Read, MDRin.
    - Stay in T1 while mem_rdy=0; PCin pulses once only.
    - Go to T2 on the cycle mem_rdy=1.
  - T2: bus_src[21], IRin.
  - T3: bus_src[rb], Yin. nop goes to T0. halt goes to HALT.
  - T4:
    - R-type: bus_src[rc], Zin, alu_op=op.
    - I-type: bus_src[23], Zin, alu_op = op mapped to add/and/or (01100→00011, 01101→00101, 01110→00110).
    - ld/st: bus_src[23], Zin, alu_op=ADD_OP.
  - T5:
    - R-type and I-type: bus_src[19], reg_in[ra]; then T0.
    - ld/st: bus_src[19], MARin.
  - T6:
    - ld: Read, MDRin; wait on mem_rdy as in T1.
    - st: bus_src[ra], MDRin.
  - T7:
    - ld: bus_src[21], reg_in[ra]; then T0.
    - st: Write; wait on mem_rdy; then T0.
  - HALT: run=0, all strobes 0. Left only by clr.
  - FAULT: run=0, fault=1, all strobes 0. Left only by clr.
- stop is sampled in T0's predecessor: if stop=1 on the edge that would enter T0, go to HALT instead.
- Wait counter:
  - Cleared on entry to T1, T6(ld) and T7(st); increments each waiting cycle.
  - If it reaches MEM_WAIT_MAX with mem_rdy still 0, go to FAULT.
  - mem_rdy=1 in the same cycle as the count reaching the limit counts as success.
- mem_rdy is ignored in all non-waiting states.
- Latency with zero-wait memory: R-type, I-type, nop and halt take 6, 6, 4 and 4 cycles respectively; ld and st take 8 cycles.
- Invariants:
  - bus_src is never multi-hot.
  - reg_in is asserted only in T5 and T7.
  - Read and Write are never high together.

Test Plan:
- Reset: hold clr 3 cycles mid-T4 → next cycle all outputs 0, run=0. Release clr → RESET then T0 with bus_src=0x100000, MARin=IncPC=Zin=1.
- add R1,R2,R3: ir=0x18918000, mem_rdy=1 → expect:
  - T3: bus_src=0x000004, Yin
  - T4: bus_src=0x000008, alu_op=00011, Zin
  - T5: bus_src=0x080000, reg_in=0x0002
  - back to T0 after 6 cycles.
- ld R5,4(R2): ir=0x02900004, mem_rdy low for 3 cycles in T6 → Read/MDRin held 4 cycles. T7: bus_src=0x200000, reg_in=0x0020. PCin pulses exactly once per instruction.
- Timeout: mem_rdy stuck 0 in T1 → after 15 wait cycles enter FAULT; fault=1, run=0, Read=0; only clr clears it.
- halt (ir=0xE0000000) and stop=1 at boundary → HALT, run=0, no further strobes; clr restarts at T0.
- Unknown op 5'b10101 → executes as nop (4 cycles); fault stays 0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit for the
// bus-based CPU datapath. Produces every datapath strobe from the state
// register (Moore), using IR fields in the execute states. Memory states hold
// on a mem_rdy handshake and fall into a sticky FAULT state on a timeout.
//
// Ports:
//   Clock                      rising-edge clock
//   clr                        synchronous active-high reset
//   ir[31:0]                   current IR contents
//   mem_rdy                    memory finished the current Read/Write
//   stop                       halt at the next instruction boundary
//   bus_src[23:0]              one-hot bus driver select (0 = idle)
//   reg_in[15:0]               R0..R15 load enables
//   MARin..IncPC               datapath load strobes
//   Read, Write                memory request, held while waiting
//   alu_op[4:0]                ALU operation select
//   run                        high while sequencing
//   fault                      memory timeout occurred
module control_sequencer #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter logic [4:0]  ADD_OP       = 5'b00011
) (
    input  logic        Clock,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    input  logic        stop,
    output logic [23:0] bus_src,
    output logic [15:0] reg_in,
    output logic        MARin,
    output logic        MDRin,
    output logic        PCin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        fault
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_T7    = 4'd8;
    localparam logic [3:0] S_HALT  = 4'd9;
    localparam logic [3:0] S_FAULT = 4'd10;

    // Bus driver indices above the register file
    localparam int unsigned B_ZLO = 19;
    localparam int unsigned B_PC  = 20;
    localparam int unsigned B_MDR = 21;
    localparam int unsigned B_C   = 23;

    logic [3:0]       state;
    logic [3:0]       nextState;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] nextWaitCnt;

    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       isLd;
    logic       isSt;
    logic       isRType;
    logic       isIType;
    logic       isHalt;
    logic       isMem;
    logic [4:0] iAluOp;
    logic [3:0] boundaryState;
    logic       waitExpired;
    logic       unusedIrBits;

    assign op = ir[31:27];
    assign ra = ir[26:23];
    assign rb = ir[22:19];
    assign rc = ir[18:15];
    // Immediate bits are consumed by the datapath's Cout driver, not here
    assign unusedIrBits = ^ir[14:0];

    // Opcode decode; anything not listed behaves as nop
    always_comb begin
        isLd    = (op == 5'b00000);
        isSt    = (op == 5'b00010);
        isRType = (op == 5'b00011) || (op == 5'b00100) ||
                  (op == 5'b00101) || (op == 5'b00110);
        isIType = (op == 5'b01100) || (op == 5'b01101) || (op == 5'b01110);
        isHalt  = (op == 5'b11100);
        isMem   = isLd || isSt;
        case (op)
            5'b01101: iAluOp = 5'b00101;
            5'b01110: iAluOp = 5'b00110;
            default:  iAluOp = 5'b00011;
        endcase
    end

    // Instruction boundary: stop diverts the T0 entry into HALT
    assign boundaryState = stop ? S_HALT : S_T0;
    // Last permitted waiting cycle with memory still not ready
    assign waitExpired   = !mem_rdy && (waitCnt == WAIT_LAST);

    // State and wait-counter registers
    always_ff @(posedge Clock) begin
        if (clr) begin
            state   <= S_RESET;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // Next-state and wait-counter logic
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        case (state)
            S_RESET: nextState = boundaryState;
            S_T0: begin
                nextState   = S_T1;
                nextWaitCnt = '0;
            end
            S_T1: begin
                if (mem_rdy)          nextState = S_T2;
                else if (waitExpired) nextState = S_FAULT;
                else                  nextWaitCnt = waitCnt + CNT_W'(1);
            end
            S_T2: nextState = S_T3;
            S_T3: begin
                if (isHalt)                     nextState = S_HALT;
                else if (isRType || isIType || isMem) nextState = S_T4;
                else                            nextState = boundaryState;
            end
            S_T4: nextState = S_T5;
            S_T5: begin
                if (isMem) begin
                    nextState   = S_T6;
                    nextWaitCnt = '0;
                end else begin
                    nextState   = boundaryState;
                end
            end
            S_T6: begin
                if (!isLd || mem_rdy) begin
                    nextState   = S_T7;
                    nextWaitCnt = '0;
                end else if (waitExpired) begin
                    nextState   = S_FAULT;
                end else begin
                    nextWaitCnt = waitCnt + CNT_W'(1);
                end
            end
            S_T7: begin
                if (!isSt || mem_rdy) nextState = boundaryState;
                else if (waitExpired) nextState = S_FAULT;
                else                  nextWaitCnt = waitCnt + CNT_W'(1);
            end
            S_HALT:  nextState = S_HALT;
            S_FAULT: nextState = S_FAULT;
            default: nextState = S_RESET;
        endcase
    end

    // Moore output decode
    always_comb begin
        bus_src = '0;
        reg_in  = '0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        PCin    = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        alu_op  = '0;
        run     = !((state == S_RESET) || (state == S_HALT) || (state == S_FAULT));
        fault   = (state == S_FAULT);
        case (state)
            S_T0: begin
                bus_src[B_PC] = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zin    = 1'b1;
                alu_op = ADD_OP;
            end
            S_T1: begin
                bus_src[B_ZLO] = 1'b1;
                // Counter is cleared on entry, so zero marks the first cycle
                PCin  = (waitCnt == '0);
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T2: begin
                bus_src[B_MDR] = 1'b1;
                IRin = 1'b1;
            end
            S_T3: begin
                bus_src = 24'(1) << rb;
                Yin     = 1'b1;
            end
            S_T4: begin
                if (isRType) begin
                    bus_src = 24'(1) << rc;
                    Zin     = 1'b1;
                    alu_op  = op;
                end else if (isIType) begin
                    bus_src[B_C] = 1'b1;
                    Zin    = 1'b1;
                    alu_op = iAluOp;
                end else if (isMem) begin
                    bus_src[B_C] = 1'b1;
                    Zin    = 1'b1;
                    alu_op = ADD_OP;
                end
            end
            S_T5: begin
                bus_src[B_ZLO] = 1'b1;
                if (isMem) MARin  = 1'b1;
                else       reg_in = 16'(1) << ra;
            end
            S_T6: begin
                MDRin = 1'b1;
                if (isLd) Read    = 1'b1;
                else      bus_src = 24'(1) << ra;
            end
            S_T7: begin
                if (isLd) begin
                    bus_src[B_MDR] = 1'b1;
                    reg_in = 16'(1) << ra;
                end else begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each scenario queues the expected
// per-cycle output vector alongside its stimulus, then replays the stimulus
// and compares the DUT outputs cycle by cycle.
module tb_control_sequencer;

    // Strobe field order: MARin MDRin PCin IRin Yin Zin IncPC Read Write
    localparam logic [8:0] MAR = 9'h100;
    localparam logic [8:0] MDR = 9'h080;
    localparam logic [8:0] PCI = 9'h040;
    localparam logic [8:0] IRI = 9'h020;
    localparam logic [8:0] YI  = 9'h010;
    localparam logic [8:0] ZI  = 9'h008;
    localparam logic [8:0] INC = 9'h004;
    localparam logic [8:0] RD  = 9'h002;
    localparam logic [8:0] WR  = 9'h001;

    typedef struct packed {
        logic [23:0] bus;
        logic [15:0] rin;
        logic [8:0]  stb;
        logic [4:0]  alu;
        logic        run;
        logic        flt;
    } outVec;

    typedef struct packed {
        logic        c;
        logic [31:0] i;
        logic        r;
        logic        s;
    } stimVec;

    logic        Clock = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] ir = '0;
    logic        mem_rdy = 1'b0;
    logic        stop = 1'b0;
    logic [23:0] bus_src;
    logic [15:0] reg_in;
    logic        MARin, MDRin, PCin, IRin, Yin, Zin, IncPC, Read, Write;
    logic [4:0]  alu_op;
    logic        run, fault;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock(Clock), .clr(clr), .ir(ir), .mem_rdy(mem_rdy), .stop(stop),
        .bus_src(bus_src), .reg_in(reg_in),
        .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .alu_op(alu_op), .run(run), .fault(fault)
    );

    outVec obs;
    always_comb obs = {bus_src, reg_in, MARin, MDRin, PCin, IRin, Yin, Zin,
                       IncPC, Read, Write, alu_op, run, fault};

    outVec  expQ[$];
    stimVec stimQ[$];
    int     total = 0;
    int     bad = 0;

    function automatic outVec mk(logic [23:0] bus, logic [15:0] rin,
                                 logic [8:0] stb, logic [4:0] alu,
                                 logic runV, logic fltV);
        mk = '{bus: bus, rin: rin, stb: stb, alu: alu, run: runV, flt: fltV};
    endfunction

    function automatic outVec eIdle();
        eIdle = mk(24'h0, 16'h0, 9'h0, 5'h0, 1'b0, 1'b0);
    endfunction

    task automatic push(outVec e, logic cv, logic [31:0] iv, logic rv, logic sv);
        expQ.push_back(e);
        stimQ.push_back('{c: cv, i: iv, r: rv, s: sv});
    endtask

    // Zero-wait fetch plus T3 (bus carries rb)
    task automatic pushFetch(logic [31:0] iv, logic [23:0] t3bus);
        push(mk(24'h100000, 16'h0, MAR | ZI | INC, 5'b00011, 1'b1, 1'b0), 1'b0, iv, 1'b1, 1'b0);
        push(mk(24'h080000, 16'h0, PCI | RD | MDR, 5'h0, 1'b1, 1'b0),    1'b0, iv, 1'b1, 1'b0);
        push(mk(24'h200000, 16'h0, IRI, 5'h0, 1'b1, 1'b0),               1'b0, iv, 1'b1, 1'b0);
        push(mk(t3bus, 16'h0, YI, 5'h0, 1'b1, 1'b0),                     1'b0, iv, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        stimVec st;
        outVec  e;
        int     cyc = 0;
        push(eIdle(), 1'b0, 32'h0, 1'b0, 1'b0);
        pushFetch(32'h18918000, 24'h000004);
        push(mk(24'h000008, 16'h0, ZI, 5'b00011, 1'b1, 1'b0), 1'b1, 32'h18918000, 1'b1, 1'b0);
        push(eIdle(), 1'b1, 32'h18918000, 1'b1, 1'b0);
        push(eIdle(), 1'b1, 32'h18918000, 1'b1, 1'b0);
        push(eIdle(), 1'b0, 32'h18918000, 1'b1, 1'b0);
        while (expQ.size() > 0) begin
            st = stimQ.pop_front(); e = expQ.pop_front();
            clr = st.c; ir = st.i; mem_rdy = st.r; stop = st.s;
            #1;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL test_reset cyc=%0d got=%h want=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_add();
        stimVec st;
        outVec  e;
        int     cyc = 0;
        pushFetch(32'h18918000, 24'h000004);
        push(mk(24'h000008, 16'h0, ZI, 5'b00011, 1'b1, 1'b0), 1'b0, 32'h18918000, 1'b1, 1'b0);
        push(mk(24'h080000, 16'h0002, 9'h0, 5'h0, 1'b1, 1'b0), 1'b0, 32'h18918000, 1'b1, 1'b0);
        while (expQ.size() > 0) begin
            st = stimQ.pop_front(); e = expQ.pop_front();
            clr = st.c; ir = st.i; mem_rdy = st.r; stop = st.s;
            #1;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL test_add cyc=%0d got=%h want=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge Clock); #1;
        end
    endtask

    // ori R4,R6,0x55 directly followed by an unknown op executing as nop
    task automatic test_back_to_back();
        stimVec st;
        outVec  e;
        int     cyc = 0;
        pushFetch(32'h72300055, 24'h000040);
        push(mk(24'h800000, 16'h0, ZI, 5'b00110, 1'b1, 1'b0), 1'b0, 32'h72300055, 1'b1, 1'b0);
        push(mk(24'h080000, 16'h0010, 9'h0, 5'h0, 1'b1, 1'b0), 1'b0, 32'h72300055, 1'b1, 1'b0);
        pushFetch(32'hA8000000, 24'h000001);
        while (expQ.size() > 0) begin
            st = stimQ.pop_front(); e = expQ.pop_front();
            clr = st.c; ir = st.i; mem_rdy = st.r; stop = st.s;
            #1;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL test_back_to_back cyc=%0d got=%h want=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge Clock); #1;
        end
    endtask

    // ld R5,4(R2) with three not-ready cycles in T6
    task automatic test_load();
        stimVec st;
        outVec  e;
        int     cyc = 0;
        pushFetch(32'h02900004, 24'h000004);
        push(mk(24'h800000, 16'h0, ZI, 5'b00011, 1'b1, 1'b0), 1'b0, 32'h02900004, 1'b1, 1'b0);
        push(mk(24'h080000, 16'h0, MAR, 5'h0, 1'b1, 1'b0),    1'b0, 32'h02900004, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            push(mk(24'h0, 16'h0, RD | MDR, 5'h0, 1'b1, 1'b0), 1'b0, 32'h02900004, (k == 3), 1'b0);
        push(mk(24'h200000, 16'h0020, 9'h0, 5'h0, 1'b1, 1'b0), 1'b0, 32'h02900004, 1'b0, 1'b0);
        while (expQ.size() > 0) begin
            st = stimQ.pop_front(); e = expQ.pop_front();
            clr = st.c; ir = st.i; mem_rdy = st.r; stop = st.s;
            #1;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL test_load cyc=%0d got=%h want=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge Clock); #1;
        end
    endtask

    // st R7,8(R1) with one not-ready cycle in T7
    task automatic test_store();
        stimVec st;
        outVec  e;
        int     cyc = 0;
        pushFetch(32'h13880008, 24'h000002);
        push(mk(24'h800000, 16'h0, ZI, 5'b00011, 1'b1, 1'b0), 1'b0, 32'h13880008, 1'b1, 1'b0);
        push(mk(24'h080000, 16'h0, MAR, 5'h0, 1'b1, 1'b0),    1'b0, 32'h13880008, 1'b1, 1'b0);
        push(mk(24'h000080, 16'h0, MDR, 5'h0, 1'b1, 1'b0),    1'b0, 32'h13880008, 1'b0, 1'b0);
        push(mk(24'h0, 16'h0, WR, 5'h0, 1'b1, 1'b0),          1'b0, 32'h13880008, 1'b0, 1'b0);
        push(mk(24'h0, 16'h0, WR, 5'h0, 1'b1, 1'b0),          1'b0, 32'h13880008, 1'b1, 1'b0);
        while (expQ.size() > 0) begin
            st = stimQ.pop_front(); e = expQ.pop_front();
            clr = st.c; ir = st.i; mem_rdy = st.r; stop = st.s;
            #1;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL test_store cyc=%0d got=%h want=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge Clock); #1;
        end
    endtask

    // mem_rdy arriving on the 15th waiting cycle still completes the fetch
    task automatic test_wait_boundary();
        stimVec st;
        outVec  e;
        int     cyc = 0;
        push(mk(24'h100000, 16'h0, MAR | ZI | INC, 5'b00011, 1'b1, 1'b0), 1'b0, 32'hD8000000, 1'b0, 1'b0);
        push(mk(24'h080000, 16'h0, PCI | RD | MDR, 5'h0, 1'b1, 1'b0),    1'b0, 32'hD8000000, 1'b0, 1'b0);
        for (int k = 0; k < 14; k++)
            push(mk(24'h080000, 16'h0, RD | MDR, 5'h0, 1'b1, 1'b0), 1'b0, 32'hD8000000, (k == 13), 1'b0);
        push(mk(24'h200000, 16'h0, IRI, 5'h0, 1'b1, 1'b0), 1'b0, 32'hD8000000, 1'b0, 1'b0);
        push(mk(24'h000001, 16'h0, YI, 5'h0, 1'b1, 1'b0),  1'b0, 32'hD8000000, 1'b0, 1'b0);
        while (expQ.size() > 0) begin
            st = stimQ.pop_front(); e = expQ.pop_front();
            clr = st.c; ir = st.i; mem_rdy = st.r; stop = st.s;
            #1;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL test_wait_boundary cyc=%0d got=%h want=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge Clock); #1;
        end
    endtask

    // stop mid-instruction is ignored; stop at the boundary enters HALT
    task automatic test_stop();
        stimVec st;
        outVec  e;
        int     cyc = 0;
        push(mk(24'h100000, 16'h0, MAR | ZI | INC, 5'b00011, 1'b1, 1'b0), 1'b0, 32'h18918000, 1'b1, 1'b1);
        push(mk(24'h080000, 16'h0, PCI | RD | MDR, 5'h0, 1'b1, 1'b0),    1'b0, 32'h18918000, 1'b1, 1'b1);
        push(mk(24'h200000, 16'h0, IRI, 5'h0, 1'b1, 1'b0),               1'b0, 32'h18918000, 1'b1, 1'b0);
        push(mk(24'h000004, 16'h0, YI, 5'h0, 1'b1, 1'b0),                1'b0, 32'h18918000, 1'b1, 1'b0);
        push(mk(24'h000008, 16'h0, ZI, 5'b00011, 1'b1, 1'b0),            1'b0, 32'h18918000, 1'b1, 1'b0);
        push(mk(24'h080000, 16'h0002, 9'h0, 5'h0, 1'b1, 1'b0),           1'b0, 32'h18918000, 1'b1, 1'b1);
        push(eIdle(), 1'b0, 32'h18918000, 1'b1, 1'b0);
        push(eIdle(), 1'b1, 32'h18918000, 1'b1, 1'b0);
        push(eIdle(), 1'b0, 32'h18918000, 1'b1, 1'b0);
        while (expQ.size() > 0) begin
            st = stimQ.pop_front(); e = expQ.pop_front();
            clr = st.c; ir = st.i; mem_rdy = st.r; stop = st.s;
            #1;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL test_stop cyc=%0d got=%h want=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge Clock); #1;
        end
    endtask

    // halt instruction parks the sequencer until clr
    task automatic test_halt();
        stimVec st;
        outVec  e;
        int     cyc = 0;
        pushFetch(32'hE0000000, 24'h000001);
        for (int k = 0; k < 3; k++)
            push(eIdle(), 1'b0, 32'hE0000000, k[0], 1'b0);
        push(eIdle(), 1'b1, 32'hE0000000, 1'b0, 1'b0);
        push(eIdle(), 1'b0, 32'hE0000000, 1'b0, 1'b0);
        while (expQ.size() > 0) begin
            st = stimQ.pop_front(); e = expQ.pop_front();
            clr = st.c; ir = st.i; mem_rdy = st.r; stop = st.s;
            #1;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL test_halt cyc=%0d got=%h want=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge Clock); #1;
        end
    endtask

    // mem_rdy stuck low in T1: 15 waiting cycles, then sticky FAULT
    task automatic test_timeout();
        stimVec st;
        outVec  e;
        int     cyc = 0;
        push(mk(24'h100000, 16'h0, MAR | ZI | INC, 5'b00011, 1'b1, 1'b0), 1'b0, 32'h18918000, 1'b0, 1'b0);
        push(mk(24'h080000, 16'h0, PCI | RD | MDR, 5'h0, 1'b1, 1'b0),    1'b0, 32'h18918000, 1'b0, 1'b0);
        for (int k = 0; k < 14; k++)
            push(mk(24'h080000, 16'h0, RD | MDR, 5'h0, 1'b1, 1'b0), 1'b0, 32'h18918000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            push(mk(24'h0, 16'h0, 9'h0, 5'h0, 1'b0, 1'b1), 1'b0, 32'h18918000, 1'b1, 1'b0);
        push(mk(24'h0, 16'h0, 9'h0, 5'h0, 1'b0, 1'b1), 1'b1, 32'h18918000, 1'b0, 1'b0);
        push(eIdle(), 1'b0, 32'h18918000, 1'b0, 1'b0);
        push(mk(24'h100000, 16'h0, MAR | ZI | INC, 5'b00011, 1'b1, 1'b0), 1'b0, 32'h18918000, 1'b0, 1'b0);
        while (expQ.size() > 0) begin
            st = stimQ.pop_front(); e = expQ.pop_front();
            clr = st.c; ir = st.i; mem_rdy = st.r; stop = st.s;
            #1;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL test_timeout cyc=%0d got=%h want=%h", cyc, obs, e);
            end
            cyc++;
            @(posedge Clock); #1;
        end
    endtask

    initial begin
        clr = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        test_reset();
        test_add();
        test_back_to_back();
        test_load();
        test_store();
        test_wait_boundary();
        test_stop();
        test_halt();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
